vme_cmd_arbiter: RTL and testbench
==================================

// Module: vme_cmd_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares the single VME command port (start/vme_cmd_reg/
//  vme_dat_reg_in -> vme_dat_wr/vme_dat_reg_out) between NREQ command sources (file-driven
//  testbench, self-test engine, BPI/config logic). Issues one transaction at a time, forms the
//  command word with address mask and R/W flag, waits for completion or timeout, returns read
//  data to the granted requester.
// PARAMETERS
//  NREQ      4             number of requesters (2..8)
//  CMD_MASK  32'h00a80000  OR-ed into every issued command word
//  TIMEOUT   255           cycles in WAIT before abort (1..65535)
// PORTS
//  clk              in   1        system clock
//  rst_n            in   1        synchronous reset, active low
//  req              in   NREQ     request, held high until ack
//  req_rd           in   NREQ     1 = read, 0 = write (per requester)
//  req_cmd          in   32*NREQ  command word, slice i = requester i
//  req_dat          in   32*NREQ  write data, slice i = requester i
//  gnt              out  NREQ     one-hot grant, high ISSUE..ACK
//  ack              out  NREQ     one-cycle completion strobe to granted requester
//  ack_dat          out  32       read data (valid with ack; 0 for writes)
//  ack_err          out  1        timeout flag, valid with ack
//  vme_cmd_rd       in   1        VME port ready to accept a command
//  start            out  1        one-cycle command strobe
//  vme_cmd_reg      out  32       issued command word
//  vme_dat_reg_in   out  32       issued write data
//  vme_dat_wr       in   1        VME completion strobe
//  vme_dat_reg_out  in   32       VME read data, valid with vme_dat_wr
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, ack=0, ack_dat=0, ack_err=0, start=0, vme_cmd_reg=CMD_MASK,
//    vme_dat_reg_in=0, rr pointer=0 (requester 0 highest priority first).
//  - IDLE: any req -> ARB next cycle.
//  - ARB: pick first req at or after pointer (wrap-around mod NREQ); latch index; gnt set.
//    If req dropped meanwhile -> IDLE, no grant.
//  - ISSUE: wait for vme_cmd_rd; when high: start=1 for exactly one cycle;
//    vme_cmd_reg = req_cmd|CMD_MASK, bit25=1 if read else bit24=1; vme_dat_reg_in = req_dat
//    (forced 0 for reads). Inputs sampled only in this cycle. -> WAIT.
//  - WAIT: timeout counter increments each cycle. vme_dat_wr -> capture vme_dat_reg_out
//    (reads) -> ACK, err=0. Counter reaching TIMEOUT without vme_dat_wr -> ACK, err=1,
//    ack_dat=0. vme_dat_wr on the same cycle as timeout: completion wins, err=0.
//  - ACK: ack[idx]=1 one cycle, ack_dat/ack_err valid; pointer = idx+1 (wrap); gnt cleared;
//    vme_cmd_reg returns to CMD_MASK, vme_dat_reg_in to 0. -> IDLE (min 5 cycles/txn).
//  - vme_dat_wr outside WAIT ignored. Requester dropping req after grant does not abort the txn.
//  - rst_n low in any state: abort immediately, outputs to reset values next edge, no ack.
// CONFIGURATION
//  VME_ARB_STATS_EN defined: extra outputs txn_cnt[15:0] (completed txns) and
//  tmo_cnt[7:0] (timeouts), both saturating, cleared by rst_n, updated in ACK.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Single write: req[0], cmd 0x00004000, dat 0x1234, vme_cmd_rd=1, vme_dat_wr 3 cyc after
//    start -> vme_cmd_reg=0x01A84000, vme_dat_reg_in=0x1234, ack[0] one cycle, ack_err=0.
//  2 Single read: req[2], cmd 0x00003000, vme_dat_reg_out=0xBEEF with vme_dat_wr ->
//    vme_cmd_reg=0x02A83000, vme_dat_reg_in=0, ack[2], ack_dat=0x0000BEEF.
//  3 Round-robin: req=4'b1111 held, each completes -> grant order 0,1,2,3,0; no requester starved.
//  4 Timeout: no vme_dat_wr -> ack_err=1 exactly TIMEOUT cycles after start, ack_dat=0;
//    next txn proceeds normally; with VME_ARB_STATS_EN tmo_cnt=1.
//  5 Back-pressure: vme_cmd_rd low 10 cycles in ISSUE -> start held low, asserts 1 cycle once
//    ready; vme_dat_wr pulsed in IDLE -> ignored, no ack.
//  6 Reset mid-WAIT: rst_n low one cycle -> all outputs reset values, no ack, pointer=0.

Source files
------------

// File: rtl/vme_cmd_arbiter.sv
// vme_cmd_arbiter: round-robin sharing of the single VME command port among NREQ sources.
// Define VME_ARB_STATS_EN to add saturating txn_cnt / tmo_cnt statistics outputs.
module vme_cmd_arbiter #(
  parameter int          NREQ     = 4,
  parameter logic [31:0] CMD_MASK = 32'h00a80000,
  parameter int          TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [32*NREQ-1:0]   req_cmd,
  input  logic [32*NREQ-1:0]   req_dat,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          ack_dat,
  output logic                 ack_err,
  input  logic                 vme_cmd_rd,
  output logic                 start,
  output logic [31:0]          vme_cmd_reg,
  output logic [31:0]          vme_dat_reg_in,
  input  logic                 vme_dat_wr,
  input  logic [31:0]          vme_dat_reg_out
`ifdef VME_ARB_STATS_EN
  ,
  output logic [15:0]          txn_cnt,
  output logic [7:0]           tmo_cnt
`endif
);

  localparam int          IDXW     = $clog2(NREQ);
  localparam logic [31:0] RD_FLAG  = 32'h0200_0000;
  localparam logic [31:0] WR_FLAG  = 32'h0100_0000;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, ACK} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx;
  logic            rd;
  logic [15:0]     tmo;
  logic [IDXW-1:0] pick;
  logic            pick_vld;
  logic [NREQ-1:0] idx_onehot;
  logic [IDXW-1:0] idx_inc;
  logic [31:0]     cmd_arr  [NREQ];
  logic [31:0]     dat_arr  [NREQ];
  logic [IDXW:0]   cand_sum [NREQ];
  logic [IDXW-1:0] cand     [NREQ];

  // cand[k] is the requester k places after the pointer, wrapped modulo NREQ
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign cmd_arr[gi]  = req_cmd[32*gi +: 32];
      assign dat_arr[gi]  = req_dat[32*gi +: 32];
      assign cand_sum[gi] = {1'b0, ptr} + (IDXW+1)'(gi);
      assign cand[gi]     = (cand_sum[gi] >= (IDXW+1)'(NREQ)) ?
                            IDXW'(cand_sum[gi] - (IDXW+1)'(NREQ)) :
                            cand_sum[gi][IDXW-1:0];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest active one wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        pick     = cand[i];
        pick_vld = 1'b1;
      end
    end
  end

  assign idx_onehot = NREQ'(1) << idx;
  assign idx_inc    = (idx == IDXW'(NREQ - 1)) ? '0 : idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      rd             <= 1'b0;
      tmo            <= '0;
      gnt            <= '0;
      ack            <= '0;
      ack_dat        <= '0;
      ack_err        <= 1'b0;
      start          <= 1'b0;
      vme_cmd_reg    <= CMD_MASK;
      vme_dat_reg_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) state <= ARB;
        end
        ARB: begin
          if (pick_vld) begin
            idx   <= pick;
            gnt   <= NREQ'(1) << pick;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (vme_cmd_rd) begin
            start          <= 1'b1;
            rd             <= req_rd[idx];
            vme_cmd_reg    <= cmd_arr[idx] | CMD_MASK | (req_rd[idx] ? RD_FLAG : WR_FLAG);
            vme_dat_reg_in <= req_rd[idx] ? '0 : dat_arr[idx];
            tmo            <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          start <= 1'b0;
          tmo   <= tmo + 16'd1;
          // A completion strobe on the timeout cycle still counts as success
          if (vme_dat_wr) begin
            ack     <= idx_onehot;
            ack_dat <= rd ? vme_dat_reg_out : '0;
            ack_err <= 1'b0;
            state   <= ACK;
          end else if (tmo == TMO_LAST) begin
            ack     <= idx_onehot;
            ack_dat <= '0;
            ack_err <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          ack            <= '0;
          ack_dat        <= '0;
          ack_err        <= 1'b0;
          gnt            <= '0;
          ptr            <= idx_inc;
          vme_cmd_reg    <= CMD_MASK;
          vme_dat_reg_in <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VME_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      tmo_cnt <= '0;
    end else if (state == ACK) begin
      if (txn_cnt != 16'hffff) txn_cnt <= txn_cnt + 16'd1;
      if (ack_err && tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Self-checking bench for vme_cmd_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, command word and completion.
module tb_vme_cmd_arbiter;

  localparam int          NREQ = 4;
  localparam logic [31:0] MASK = 32'h00a80000;
  localparam int          TMO  = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_rd = '0;
  logic [32*NREQ-1:0]  req_cmd = '0;
  logic [32*NREQ-1:0]  req_dat = '0;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     ack;
  logic [31:0]         ack_dat;
  logic                ack_err;
  logic                vme_cmd_rd = 1'b0;
  logic                start;
  logic [31:0]         vme_cmd_reg;
  logic [31:0]         vme_dat_reg_in;
  logic                vme_dat_wr = 1'b0;
  logic [31:0]         vme_dat_reg_out = '0;
`ifdef VME_ARB_STATS_EN
  logic [15:0]         txn_cnt;
  logic [7:0]          tmo_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;

  typedef struct packed {
    logic            ok;
    logic [15:0]     early_start;
    logic [15:0]     issue_wait;
    logic [15:0]     start_cycles;
    logic [15:0]     lat;
    logic [NREQ-1:0] gnt_start;
    logic [NREQ-1:0] gnt_ack;
    logic [NREQ-1:0] ack_v;
    logic [NREQ-1:0] ack_after;
    logic [NREQ-1:0] gnt_after;
    logic [31:0]     cmd;
    logic [31:0]     dat;
    logic [31:0]     ack_dat;
    logic [31:0]     cmd_after;
    logic [31:0]     dat_after;
    logic            ack_err;
  } obs_t;

  vme_cmd_arbiter #(.NREQ(NREQ), .CMD_MASK(MASK), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_rd          (req_rd),
    .req_cmd         (req_cmd),
    .req_dat         (req_dat),
    .gnt             (gnt),
    .ack             (ack),
    .ack_dat         (ack_dat),
    .ack_err         (ack_err),
    .vme_cmd_rd      (vme_cmd_rd),
    .start           (start),
    .vme_cmd_reg     (vme_cmd_reg),
    .vme_dat_reg_in  (vme_dat_reg_in),
    .vme_dat_wr      (vme_dat_wr),
    .vme_dat_reg_out (vme_dat_reg_out)
`ifdef VME_ARB_STATS_EN
    ,
    .txn_cnt         (txn_cnt),
    .tmo_cnt         (tmo_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: first requester at or after the pointer, modulo NREQ
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] model_cmd(input logic [31:0] c, input logic rd);
    return c | MASK | (rd ? 32'h0200_0000 : 32'h0100_0000);
  endfunction

  // Drives the VME side of one transaction and records what the DUT did
  task automatic run_txn(input int rd_dly, input int rsp_dly, input logic [31:0] rsp,
                         output obs_t o);
    int n;
    o = '0;
    o.ok = 1'b1;
    vme_cmd_rd = (rd_dly == 0);
    n = 0;
    while (gnt === '0 && n < 10) begin tick(); n++; end
    if (gnt === '0) begin o.ok = 1'b0; return; end
    for (int i = 0; i < rd_dly; i++) begin
      if (start !== 1'b0) o.early_start++;
      tick();
    end
    vme_cmd_rd = 1'b1;
    n = 0;
    while (start !== 1'b1 && n < 5) begin tick(); n++; end
    if (start !== 1'b1) begin o.ok = 1'b0; vme_cmd_rd = 1'b0; return; end
    o.issue_wait = 16'(n);
    o.gnt_start = gnt;
    o.cmd = vme_cmd_reg;
    o.dat = vme_dat_reg_in;
    vme_cmd_rd = 1'b0;
    n = 0;
    while (ack === '0 && n < TMO + 20) begin
      if (start === 1'b1) o.start_cycles++;
      if (rsp_dly >= 0 && n == rsp_dly) begin
        vme_dat_wr = 1'b1;
        vme_dat_reg_out = rsp;
      end else begin
        vme_dat_wr = 1'b0;
        vme_dat_reg_out = $urandom;
      end
      tick();
      n++;
    end
    vme_dat_wr = 1'b0;
    if (ack === '0) begin o.ok = 1'b0; return; end
    o.lat = 16'(n);
    o.ack_v = ack;
    o.ack_dat = ack_dat;
    o.ack_err = ack_err;
    o.gnt_ack = gnt;
    tick();
    o.ack_after = ack;
    o.gnt_after = gnt;
    o.cmd_after = vme_cmd_reg;
    o.dat_after = vme_dat_reg_in;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rst_gnt: got %b expected 0", gnt); end
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL rst_ack: got %b expected 0", ack); end
    n_cmp++; if (start !== 1'b0 || ack_err !== 1'b0 || ack_dat !== '0) begin
      n_bad++; $display("FAIL rst_misc: start %b err %b dat %h expected 0/0/0", start, ack_err, ack_dat); end
    n_cmp++; if (vme_cmd_reg !== MASK) begin n_bad++; $display("FAIL rst_cmd: got %h expected %h", vme_cmd_reg, MASK); end
    n_cmp++; if (vme_dat_reg_in !== '0) begin n_bad++; $display("FAIL rst_dat: got %h expected 0", vme_dat_reg_in); end
    rst_n = 1'b1;
    tick();
    ptr_m = 0;
  endtask

  task automatic test_single_write();
    obs_t o;
    req_cmd[31:0] = 32'h0000_4000;
    req_dat[31:0] = 32'h0000_1234;
    req_rd = '0;
    req = 4'b0001;
    run_txn(0, 3, 32'hdead_0000, o);
    req = '0;
    n_cmp++; if (!o.ok) begin n_bad++; $display("FAIL wr_handshake: got incomplete expected complete"); end
    n_cmp++; if (o.gnt_start !== 4'b0001) begin n_bad++; $display("FAIL wr_gnt: got %b expected 0001", o.gnt_start); end
    n_cmp++; if (o.cmd !== 32'h01A8_4000) begin n_bad++; $display("FAIL wr_cmd: got %h expected 01a84000", o.cmd); end
    n_cmp++; if (o.dat !== 32'h0000_1234) begin n_bad++; $display("FAIL wr_dat: got %h expected 00001234", o.dat); end
    n_cmp++; if (o.ack_v !== 4'b0001 || o.ack_after !== '0) begin
      n_bad++; $display("FAIL wr_ack: got %b then %b expected 0001 then 0000", o.ack_v, o.ack_after); end
    n_cmp++; if (o.ack_err !== 1'b0 || o.ack_dat !== '0) begin
      n_bad++; $display("FAIL wr_ackinfo: err %b dat %h expected 0/0", o.ack_err, o.ack_dat); end
    n_cmp++; if (o.lat !== 16'd4) begin n_bad++; $display("FAIL wr_latency: got %0d expected 4", o.lat); end
    n_cmp++; if (o.start_cycles !== 16'd1) begin n_bad++; $display("FAIL wr_start_width: got %0d expected 1", o.start_cycles); end
    n_cmp++; if (o.gnt_after !== '0 || o.cmd_after !== MASK || o.dat_after !== '0) begin
      n_bad++; $display("FAIL wr_release: gnt %b cmd %h dat %h expected 0/%h/0", o.gnt_after, o.cmd_after, o.dat_after, MASK); end
    $display("txn single_write: gnt=%b cmd=%h dat=%h lat=%0d", o.gnt_start, o.cmd, o.dat, o.lat);
    ptr_m = 1;
  endtask

  task automatic test_single_read();
    obs_t o;
    req_cmd[64 +: 32] = 32'h0000_3000;
    req_dat[64 +: 32] = 32'hffff_ffff;
    req_rd = 4'b0100;
    req = 4'b0100;
    run_txn(0, 2, 32'h0000_BEEF, o);
    req = '0;
    n_cmp++; if (!o.ok) begin n_bad++; $display("FAIL rd_handshake: got incomplete expected complete"); end
    n_cmp++; if (o.gnt_start !== 4'b0100 || o.gnt_ack !== 4'b0100) begin
      n_bad++; $display("FAIL rd_gnt: got %b/%b expected 0100", o.gnt_start, o.gnt_ack); end
    n_cmp++; if (o.cmd !== 32'h02A8_3000) begin n_bad++; $display("FAIL rd_cmd: got %h expected 02a83000", o.cmd); end
    n_cmp++; if (o.dat !== '0) begin n_bad++; $display("FAIL rd_dat: got %h expected 0", o.dat); end
    n_cmp++; if (o.ack_v !== 4'b0100) begin n_bad++; $display("FAIL rd_ack: got %b expected 0100", o.ack_v); end
    n_cmp++; if (o.ack_dat !== 32'h0000_BEEF || o.ack_err !== 1'b0) begin
      n_bad++; $display("FAIL rd_ackdat: got %h err %b expected 0000beef err 0", o.ack_dat, o.ack_err); end
    $display("txn single_read: gnt=%b cmd=%h ack_dat=%h", o.gnt_start, o.cmd, o.ack_dat);
    ptr_m = 3;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < NREQ; s++) begin
      req_cmd[32*s +: 32] = $urandom;
      req_dat[32*s +: 32] = $urandom;
    end
    req_rd = 4'($urandom);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      run_txn(0, int'($urandom_range(0, 4)), $urandom, o);
      n_cmp++; if (!o.ok || o.ack_v !== (NREQ'(1) << exp_seq[t])) begin
        n_bad++; $display("FAIL rr_order[%0d]: got ack %b expected requester %0d", t, o.ack_v, exp_seq[t]); end
      $display("txn round_robin %0d: gnt=%b ack=%b", t, o.gnt_start, o.ack_v);
    end
    req = '0;
    tick();
    ptr_m = 1;
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] rsp;
    req_cmd[32 +: 32] = 32'h0000_0100;
    req_dat[32 +: 32] = 32'h5555_aaaa;
    req_rd = 4'b0000;
    req = 4'b0010;
    run_txn(0, -1, 32'h0, o);
    req = '0;
    n_cmp++; if (!o.ok || o.ack_v !== 4'b0010) begin n_bad++; $display("FAIL tmo_ack: got %b expected 0010", o.ack_v); end
    n_cmp++; if (o.ack_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", o.ack_err); end
    n_cmp++; if (o.lat !== 16'(TMO)) begin n_bad++; $display("FAIL tmo_latency: got %0d expected %0d", o.lat, TMO); end
    n_cmp++; if (o.ack_dat !== '0) begin n_bad++; $display("FAIL tmo_dat: got %h expected 0", o.ack_dat); end
    $display("txn timeout: ack=%b err=%b lat=%0d", o.ack_v, o.ack_err, o.lat);
    // Completion arriving on the last cycle before timeout must win
    rsp = $urandom;
    req_rd = 4'b0010;
    req = 4'b0010;
    run_txn(0, TMO - 1, rsp, o);
    req = '0;
    n_cmp++; if (!o.ok || o.ack_err !== 1'b0) begin n_bad++; $display("FAIL tie_err: got %b expected 0", o.ack_err); end
    n_cmp++; if (o.ack_dat !== rsp) begin n_bad++; $display("FAIL tie_dat: got %h expected %h", o.ack_dat, rsp); end
    n_cmp++; if (o.lat !== 16'(TMO)) begin n_bad++; $display("FAIL tie_latency: got %0d expected %0d", o.lat, TMO); end
    $display("txn timeout_tie: ack=%b err=%b dat=%h", o.ack_v, o.ack_err, o.ack_dat);
`ifdef VME_ARB_STATS_EN
    n_cmp++; if (tmo_cnt !== 8'd1) begin n_bad++; $display("FAIL stats_tmo: got %0d expected 1", tmo_cnt); end
    n_cmp++; if (txn_cnt !== 16'd7) begin n_bad++; $display("FAIL stats_txn: got %0d expected 7", txn_cnt); end
`endif
    ptr_m = 2;
  endtask

  task automatic test_back_pressure();
    obs_t o;
    int bad;
    req_cmd[96 +: 32] = 32'h0000_0770;
    req_dat[96 +: 32] = 32'h0bad_cafe;
    req_rd = '0;
    req = 4'b1000;
    run_txn(10, 1, 32'h0, o);
    req = '0;
    n_cmp++; if (!o.ok || o.early_start !== '0) begin
      n_bad++; $display("FAIL bp_early_start: got %0d early strobes expected 0", o.early_start); end
    n_cmp++; if (o.issue_wait !== 16'd1) begin n_bad++; $display("FAIL bp_issue_wait: got %0d expected 1", o.issue_wait); end
    n_cmp++; if (o.start_cycles !== 16'd1) begin n_bad++; $display("FAIL bp_start_width: got %0d expected 1", o.start_cycles); end
    n_cmp++; if (o.ack_v !== 4'b1000 || o.cmd !== model_cmd(32'h0000_0770, 1'b0)) begin
      n_bad++; $display("FAIL bp_txn: ack %b cmd %h expected 1000 %h", o.ack_v, o.cmd, model_cmd(32'h0000_0770, 1'b0)); end
    $display("txn back_pressure: gnt=%b cmd=%h", o.gnt_start, o.cmd);
    tick();
    vme_dat_wr = 1'b1;
    vme_dat_reg_out = 32'h1111_2222;
    tick();
    vme_dat_wr = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack !== '0 || gnt !== '0 || start !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL idle_strobe: got %0d active cycles expected 0", bad); end
    $display("txn idle_strobe: active_cycles=%0d", bad);
    ptr_m = 0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [NREQ-1:0] m;
    int w, rsp_dly;
    logic rd, err_e;
    logic [31:0] c, d, rsp, ack_dat_e;
    int lat_e;
    for (int t = 0; t < 30; t++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int s = 0; s < NREQ; s++) begin
        req_cmd[32*s +: 32] = $urandom;
        req_dat[32*s +: 32] = $urandom;
      end
      req_rd = NREQ'($urandom);
      w = model_pick(m, ptr_m);
      rd = req_rd[w];
      c = req_cmd[32*w +: 32];
      d = req_dat[32*w +: 32];
      rsp_dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
      rsp = $urandom;
      err_e = (rsp_dly < 0);
      lat_e = err_e ? TMO : rsp_dly + 1;
      ack_dat_e = (!err_e && rd) ? rsp : 32'h0;
      req = m;
      run_txn(int'($urandom_range(0, 3)), rsp_dly, rsp, o);
      n_cmp++; if (!o.ok || o.gnt_start !== (NREQ'(1) << w) || o.ack_v !== (NREQ'(1) << w)) begin
        n_bad++; $display("FAIL rnd_gnt[%0d]: got gnt %b ack %b expected requester %0d", t, o.gnt_start, o.ack_v, w); end
      n_cmp++; if (o.cmd !== model_cmd(c, rd) || o.dat !== (rd ? 32'h0 : d)) begin
        n_bad++; $display("FAIL rnd_cmd[%0d]: got %h/%h expected %h/%h", t, o.cmd, o.dat, model_cmd(c, rd), rd ? 32'h0 : d); end
      n_cmp++; if (o.ack_err !== err_e || o.ack_dat !== ack_dat_e || o.lat !== 16'(lat_e)) begin
        n_bad++; $display("FAIL rnd_done[%0d]: got err %b dat %h lat %0d expected %b %h %0d",
                          t, o.ack_err, o.ack_dat, o.lat, err_e, ack_dat_e, lat_e); end
      $display("txn random %0d: req=%b gnt=%b rd=%b err=%b lat=%0d", t, m, o.gnt_start, rd, o.ack_err, o.lat);
      ptr_m = (w + 1) % NREQ;
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int n, bad;
    req_rd = '0;
    req = 4'b0100;
    run_txn(0, 1, 32'h0, o);
    req = '0;
    n_cmp++; if (!o.ok || o.ack_v !== 4'b0100) begin n_bad++; $display("FAIL mw_pre: got %b expected 0100", o.ack_v); end
    tick();
    req = 4'b1000;
    vme_cmd_rd = 1'b1;
    n = 0;
    while (start !== 1'b1 && n < 10) begin tick(); n++; end
    vme_cmd_rd = 1'b0;
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL mw_start: got %b expected 1", start); end
    tick();
    tick();
    rst_n = 1'b0;
    req = '0;
    tick();
    n_cmp++; if (gnt !== '0 || ack !== '0 || start !== 1'b0) begin
      n_bad++; $display("FAIL mw_ctrl: gnt %b ack %b start %b expected 0/0/0", gnt, ack, start); end
    n_cmp++; if (vme_cmd_reg !== MASK || vme_dat_reg_in !== '0 || ack_dat !== '0 || ack_err !== 1'b0) begin
      n_bad++; $display("FAIL mw_data: cmd %h dat %h ackdat %h err %b expected %h/0/0/0",
                        vme_cmd_reg, vme_dat_reg_in, ack_dat, ack_err, MASK); end
    rst_n = 1'b1;
    vme_dat_wr = 1'b1;
    vme_dat_reg_out = $urandom;
    tick();
    vme_dat_wr = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack !== '0 || gnt !== '0) bad++;
      tick();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mw_no_ack: got %0d active cycles expected 0", bad); end
    req = 4'b1111;
    run_txn(0, 2, 32'h0, o);
    req = '0;
    n_cmp++; if (!o.ok || o.ack_v !== 4'b0001) begin
      n_bad++; $display("FAIL mw_ptr: got ack %b expected 0001", o.ack_v); end
    $display("txn reset_mid_wait: post-reset gnt=%b", o.gnt_start);
    ptr_m = 1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_back_pressure();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
